// File: rtl/config_row_sequencer.sv
// Row/group sweep sequencer for configuration-memory frame writes.
// One column frame is consumed and written per row, group-major.
module config_row_sequencer #(
  parameter int N_GROUPS   = 19,
  parameter int N_BLOCKS   = 9,
  parameter int COL_W      = 32,
  parameter int WR_CYCLES  = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             io_start,
  input  logic             io_abort,
  input  logic             io_inValid,
  output logic             io_inReady,
  input  logic [COL_W-1:0] io_inData,
  output logic [5:0]       io_rAddr,
  output logic [3:0]       io_bAddr,
  output logic [COL_W-1:0] io_colData,
  output logic             io_colDrive,
  output logic             io_busy,
  output logic             io_done,
  output logic             io_aborted
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam logic [5:0] NO_ROW   = 6'h3F;
  localparam logic [5:0] G_LAST   = 6'(N_GROUPS - 1);
  localparam logic [3:0] B_LAST   = 4'(N_BLOCKS - 1);
  localparam logic [7:0] WR_LAST  = 8'(WR_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [5:0]       g_q, g_d;
  logic [3:0]       b_q, b_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [COL_W-1:0] col_d;
  logic             done_d;
  logic             abort_d;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    col_d   = io_colData;
    done_d  = 1'b0;
    abort_d = 1'b0;
    if (state_q != S_IDLE && io_abort) begin
      // abort wins over handshake and done
      state_d = S_IDLE;
      g_d     = '0;
      b_d     = '0;
      cnt_d   = '0;
      abort_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (io_start && !io_abort) begin
            state_d = S_LOAD;
            g_d     = '0;
            b_d     = '0;
          end
        end
        S_LOAD: begin
          if (io_inValid && io_inReady) begin
            col_d   = io_inData;
            state_d = S_SETUP;
          end
        end
        S_SETUP: begin
          state_d = S_WRITE;
          cnt_d   = '0;
        end
        S_WRITE: begin
          if (cnt_q == WR_LAST) begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_HOLD: begin
          if (cnt_q != GAP_LAST) begin
            cnt_d = cnt_q + 8'd1;
          end else if (g_q == G_LAST && b_q == B_LAST) begin
            state_d = S_IDLE;
            g_d     = '0;
            b_d     = '0;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
            if (b_q == B_LAST) begin
              b_d = '0;
              g_d = g_q + 6'd1;
            end else begin
              b_d = b_q + 4'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      g_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      io_inReady  <= 1'b0;
      io_rAddr    <= NO_ROW;
      io_bAddr    <= '0;
      io_colData  <= '0;
      io_colDrive <= 1'b0;
      io_busy     <= 1'b0;
      io_done     <= 1'b0;
      io_aborted  <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      io_inReady  <= (state_d == S_LOAD);
      io_rAddr    <= (state_d == S_WRITE) ? g_d : NO_ROW;
      io_bAddr    <= b_d;
      io_colData  <= col_d;
      io_colDrive <= (state_d == S_SETUP) || (state_d == S_WRITE) ||
                     (state_d == S_HOLD);
      io_busy     <= (state_d != S_IDLE);
      io_done     <= done_d;
      io_aborted  <= abort_d;
    end
  end

endmodule

// File: tb/tb_config_row_sequencer.sv
// Randomized-data sweep bench for config_row_sequencer.
// Expected write order/timing derived from row arithmetic.
module tb_config_row_sequencer;

  localparam int NG    = 19;
  localparam int NB    = 9;
  localparam int WRC   = 2;
  localparam int NROWS = NG * NB;
  localparam int ROWC  = 2 + WRC + 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        io_start, io_abort, io_inValid, io_inReady;
  logic [31:0] io_inData, io_colData;
  logic [5:0]  io_rAddr;
  logic [3:0]  io_bAddr;
  logic        io_colDrive, io_busy, io_done, io_aborted;

  logic        s_start, s_abort, s_valid, s_ready;
  logic [31:0] s_data, s_colData;
  logic [5:0]  s_rAddr;
  logic [3:0]  s_bAddr;
  logic        s_colDrive, s_busy, s_done, s_aborted;

  int total = 0;
  int bad   = 0;
  logic [31:0] data [NROWS];
  logic [31:0] d2 [2];

  always #5 clk = ~clk;

  config_row_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .io_start(io_start), .io_abort(io_abort),
    .io_inValid(io_inValid), .io_inReady(io_inReady),
    .io_inData(io_inData), .io_rAddr(io_rAddr),
    .io_bAddr(io_bAddr), .io_colData(io_colData),
    .io_colDrive(io_colDrive), .io_busy(io_busy),
    .io_done(io_done), .io_aborted(io_aborted)
  );

  config_row_sequencer #(
    .N_GROUPS(2), .N_BLOCKS(1), .COL_W(32),
    .WR_CYCLES(1), .GAP_CYCLES(1)
  ) dut2 (
    .clk(clk), .reset_n(reset_n),
    .io_start(s_start), .io_abort(s_abort),
    .io_inValid(s_valid), .io_inReady(s_ready),
    .io_inData(s_data), .io_rAddr(s_rAddr),
    .io_bAddr(s_bAddr), .io_colData(s_colData),
    .io_colDrive(s_colDrive), .io_busy(s_busy),
    .io_done(s_done), .io_aborted(s_aborted)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one sweep from IDLE; start pulse is cycle 0.
  task automatic sweep(input int stall_at, input int abort_at,
                       input int rst_at, input int busy_at);
    int fed, wc, stall, row, cyc;
    bit fin;
    fed = 0; wc = 0; stall = 0; fin = 0; cyc = 1;
    foreach (data[i]) data[i] = $urandom;
    io_inData  = data[0];
    io_inValid = 1'b1;
    io_start   = 1'b1;
    tick;
    io_start = 1'b0;
    while (cyc < 1500 && !fin) begin
      io_start = (cyc == busy_at);
      if (io_rAddr != 6'h3F) begin
        row = wc / WRC;
        if (wc == 0) check("first_write_cycle", 64'(cyc), 64'd3);
        if (row < NROWS)
          check("write", {io_rAddr, io_bAddr, io_colDrive, io_colData},
                {6'(row / NB), 4'(row % NB), 1'b1, data[row]});
        else
          check("extra_write", 64'(row), 64'(NROWS - 1));
        if (wc % WRC == 0 && row == abort_at) begin
          io_abort = 1'b1;
          tick;
          io_abort = 1'b0;
          check("abort", {io_rAddr, io_colDrive, io_aborted,
                          io_busy, io_inReady},
                {6'h3F, 1'b0, 1'b1, 1'b0, 1'b0});
          fin = 1;
        end else if (wc % WRC == 0 && row == rst_at) begin
          reset_n = 1'b0;
          #1;
          check("async_reset", {io_rAddr, io_colDrive, io_busy},
                {6'h3F, 1'b0, 1'b0});
          fin = 1;
        end
        wc++;
      end
      if (!fin) begin
        if (io_inReady && fed == stall_at && stall < 10) begin
          io_inValid = 1'b0;
          check("stall", {io_inReady, io_rAddr, io_colDrive},
                {1'b1, 6'h3F, 1'b0});
          stall++;
        end else begin
          io_inValid = 1'b1;
        end
        io_inData = (fed < NROWS) ? data[fed] : 32'h0;
        if (io_inReady && io_inValid) fed++;
        if (io_done) begin
          check("done_cycle", 64'(cyc), 64'(ROWC * NROWS + 1 + stall));
          check("rows_written", 64'(wc / WRC), 64'(NROWS));
          check("done_busy", 64'(io_busy), 64'd0);
          fin = 1;
        end else begin
          tick;
          cyc++;
        end
      end
    end
    io_start = 1'b0;
    check("sweep_finished", 64'(fin), 64'd1);
  endtask

  initial begin
    int fed2, wr_r, base;
    reset_n = 1'b0;
    io_start = 0; io_abort = 0; io_inValid = 0; io_inData = '0;
    s_start = 0; s_abort = 0; s_valid = 0; s_data = '0;
    repeat (2) tick;
    check("rst_raddr", 64'(io_rAddr), 64'h3F);
    check("rst_outs", {io_bAddr, io_colData, io_inReady, io_colDrive,
                       io_busy, io_done, io_aborted}, 64'd0);
    check("rst_raddr2", 64'(s_rAddr), 64'h3F);
    reset_n = 1'b1;
    tick;

    sweep(-1, -1, -1, -1);
    tick;
    sweep(-1, -1, -1, 40);
    tick;
    sweep(31, -1, -1, -1);
    tick;
    sweep(-1, 7 * NB + 2, -1, -1);
    tick;
    sweep(-1, 5, -1, -1);
    tick;

    sweep(-1, -1, 5 * NB + 3, -1);
    tick;
    check("reset_hold", {io_rAddr, io_busy, io_colData},
          {6'h3F, 1'b0, 32'h0});
    reset_n = 1'b1;
    tick;
    sweep(-1, 0, -1, -1);
    tick;

    io_start = 1'b1; io_abort = 1'b1;
    tick;
    check("idle_start_abort", {io_busy, io_aborted, io_inReady, io_rAddr},
          {1'b0, 1'b0, 1'b0, 6'h3F});
    io_start = 1'b0; io_abort = 1'b0;
    tick;
    check("idle_stays", {io_busy, io_aborted, io_inReady, io_rAddr},
          {1'b0, 1'b0, 1'b0, 6'h3F});

    d2[0] = $urandom;
    d2[1] = $urandom;
    fed2 = 0;
    base = 6;
    s_data = d2[0];
    s_start = 1'b1;
    tick;
    s_start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      s_valid = (c >= base);
      s_data = d2[(fed2 < 2) ? fed2 : 1];
      wr_r = -1;
      for (int r = 0; r < 2; r++)
        if (c == base + 2 + 4 * r) wr_r = r;
      check("small_raddr", 64'(s_rAddr),
            (wr_r >= 0) ? 64'(wr_r) : 64'h3F);
      if (wr_r >= 0)
        check("small_coldata", 64'(s_colData), 64'(d2[wr_r]));
      check("small_done", 64'(s_done), 64'(c == base + 4 * 2));
      if (s_ready && s_valid) fed2++;
      tick;
    end
    check("small_frames", 64'(fed2), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
